// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, output port indices, requester FSM states.
package noc_pkg;

    localparam int unsigned NPORTS = 5;
    localparam int unsigned PORT_W = 3;

    localparam logic [PORT_W-1:0] P_LOCAL = 3'd0;
    localparam logic [PORT_W-1:0] P_NORTH = 3'd1;
    localparam logic [PORT_W-1:0] P_EAST  = 3'd2;
    localparam logic [PORT_W-1:0] P_SOUTH = 3'd3;
    localparam logic [PORT_W-1:0] P_WEST  = 3'd4;

    localparam logic [1:0] FT_BODY     = 2'b00;
    localparam logic [1:0] FT_HEAD     = 2'b01;
    localparam logic [1:0] FT_TAIL     = 2'b10;
    localparam logic [1:0] FT_HEADTAIL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    // Head and head+tail both open a packet.
    function automatic logic is_head(input logic [1:0] ftype);
        return (ftype == FT_HEAD) || (ftype == FT_HEADTAIL);
    endfunction

    // Tail and head+tail both close a packet.
    function automatic logic is_tail(input logic [1:0] ftype);
        return (ftype == FT_TAIL) || (ftype == FT_HEADTAIL);
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Input flit buffer: wrap-bit pointers, no read-through, full blocks writes even while popping.
module flit_fifo #(
    parameter int unsigned FLIT_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [FLIT_W-1:0] wdata,
    input  logic              pop,
    output logic [FLIT_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [FLIT_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/input_port_requester.sv
// Router input port: buffers flits, XY-routes heads, requests an output arbiter and streams packets.
module input_port_requester
    import noc_pkg::*;
#(
    parameter int unsigned FLIT_W  = 16,
    parameter int unsigned COORD_W = 3,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CUR_X   = 0,
    parameter int unsigned CUR_Y   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              in_ready,
    output logic [NPORTS-1:0] req_out,
    input  logic [NPORTS-1:0] gnt_in,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit,
    output logic [PORT_W-1:0] out_port,
    output logic              drop_err
);

    localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);

    state_t              state, state_n;
    logic [PORT_W-1:0]   sel, sel_n;
    logic [PORT_W-1:0]   route;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FLIT_W-1:0]   head_flit;
    logic [1:0]          head_type;
    logic [COORD_W-1:0]  dest_x;
    logic [COORD_W-1:0]  dest_y;
    logic                gnt_sel;

    flit_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata (in_flit),
        .pop   (fifo_pop),
        .rdata (head_flit),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign out_flit  = head_flit;
    assign out_port  = sel;
    assign head_type = head_flit[FLIT_W-1 -: 2];
    assign dest_x    = head_flit[2*COORD_W-1 -: COORD_W];
    assign dest_y    = head_flit[COORD_W-1:0];
    assign gnt_sel   = gnt_in[sel];

    // XY routing: resolve X first, then Y, else deliver locally.
    always_comb begin
        route = P_LOCAL;
        if (dest_x > CX)      route = P_EAST;
        else if (dest_x < CX) route = P_WEST;
        else if (dest_y > CY) route = P_NORTH;
        else if (dest_y < CY) route = P_SOUTH;
    end

    // State and selected-output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            sel   <= P_LOCAL;
        end else begin
            state <= state_n;
            sel   <= sel_n;
        end
    end

    // Next-state and request/transfer decode; the grant cycle already carries the head flit.
    always_comb begin
        state_n   = state;
        sel_n     = sel;
        fifo_pop  = 1'b0;
        drop_err  = 1'b0;
        out_valid = 1'b0;
        req_out   = '0;
        unique case (state)
            ST_IDLE: begin
                // Grants are ignored here: the previous packet's grant may still be high.
                if (!fifo_empty) begin
                    if (is_head(head_type)) begin
                        sel_n   = route;
                        state_n = ST_REQ;
                    end else begin
                        fifo_pop = 1'b1;
                        drop_err = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                req_out = NPORTS'(1) << sel;
                if (gnt_sel) begin
                    out_valid = !fifo_empty;
                    fifo_pop  = out_valid;
                    state_n   = (out_valid && is_tail(head_type)) ? ST_IDLE : ST_SEND;
                end
            end
            ST_SEND: begin
                req_out   = NPORTS'(1) << sel;
                out_valid = gnt_sel && !fifo_empty;
                fifo_pop  = out_valid;
                if (out_valid && is_tail(head_type)) state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_input_port_requester.sv
// Self-checking bench: routing table, hand-written multi-cycle sequences, randomized scoreboard run.
module tb_input_port_requester;

    localparam int FLIT_W  = 16;
    localparam int COORD_W = 3;
    localparam int DEPTH   = 4;
    localparam int CUR_X   = 1;
    localparam int CUR_Y   = 1;
    localparam int NPKT    = 60;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [FLIT_W-1:0] in_flit;
    logic              in_ready;
    logic [4:0]        req_out;
    logic [4:0]        gnt_in;
    logic              out_valid;
    logic [FLIT_W-1:0] out_flit;
    logic [2:0]        out_port;
    logic              drop_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] dx;
        logic [2:0] dy;
        logic [4:0] req;
        logic [2:0] port;
    } rt_vec_t;

    rt_vec_t           tbl [7];
    logic [FLIT_W-1:0] pk [4];
    logic [FLIT_W-1:0] xf;
    logic [FLIT_W-1:0] stim [$];
    logic [FLIT_W-1:0] sb [$];
    logic [FLIT_W-1:0] fr;
    logic [4:0]        req_prev;
    logic [4:0]        gnt_prev;
    bit                in_pkt;
    bit                exp_ready;
    bit                acc;
    int                pkt_port;
    int                strays;
    int                drops;
    int                tails;
    int                ncyc;
    int                plen;
    int                px;
    int                py;

    always #5 clk = ~clk;

    input_port_requester #(
        .FLIT_W  (FLIT_W),
        .COORD_W (COORD_W),
        .DEPTH   (DEPTH),
        .CUR_X   (CUR_X),
        .CUR_Y   (CUR_Y)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .req_out   (req_out),
        .gnt_in    (gnt_in),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .out_port  (out_port),
        .drop_err  (drop_err)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Flit layout: {type[1:0], payload[7:0], x[2:0], y[2:0]}.
    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input int x, input int y, input logic [7:0] pl);
        logic [2:0] xx;
        logic [2:0] yy;
        xx = 3'(x);
        yy = 3'(y);
        return {t, pl, xx, yy};
    endfunction

    function automatic bit f_head(input logic [FLIT_W-1:0] f);
        return (f[15:14] == 2'b01) || (f[15:14] == 2'b11);
    endfunction

    function automatic bit f_tail(input logic [FLIT_W-1:0] f);
        return (f[15:14] == 2'b10) || (f[15:14] == 2'b11);
    endfunction

    // Reference XY route: 0 Local, 1 North, 2 East, 3 South, 4 West.
    function automatic int route_of(input logic [FLIT_W-1:0] f);
        int x;
        int y;
        x = int'(f[5:3]);
        y = int'(f[2:0]);
        if (x > CUR_X) return 2;
        if (x < CUR_X) return 4;
        if (y > CUR_Y) return 1;
        if (y < CUR_Y) return 3;
        return 0;
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // One head+tail flit, granted as soon as the request is visible.
    task automatic single_flit(input int idx, input rt_vec_t v);
        logic [FLIT_W-1:0] f;
        f = mk(2'b11, int'(v.dx), int'(v.dy), 8'(idx + 16));
        nxt(); in_valid = 1'b1; in_flit = f; #1;
        chk("sf_in_ready", 32'(in_ready), 32'd1);
        nxt(); in_valid = 1'b0; #1;
        chk("sf_idle_req", 32'(req_out), 32'd0);
        nxt(); #1;
        chk("sf_req", 32'(req_out), 32'(v.req));
        chk("sf_no_valid_before_gnt", 32'(out_valid), 32'd0);
        nxt(); gnt_in = v.req; #1;
        chk("sf_valid", 32'(out_valid), 32'd1);
        chk("sf_port", 32'(out_port), 32'(v.port));
        chk("sf_flit", 32'(out_flit), 32'(f));
        nxt(); #1;
        chk("sf_req_released", 32'(req_out), 32'd0);
        chk("sf_stale_gnt_no_xfer", 32'(out_valid), 32'd0);
        nxt(); gnt_in = '0; #1;
    endtask

    initial begin
        tbl[0] = '{dx: 3'd3, dy: 3'd1, req: 5'b00100, port: 3'd2};
        tbl[1] = '{dx: 3'd0, dy: 3'd5, req: 5'b10000, port: 3'd4};
        tbl[2] = '{dx: 3'd1, dy: 3'd4, req: 5'b00010, port: 3'd1};
        tbl[3] = '{dx: 3'd1, dy: 3'd0, req: 5'b01000, port: 3'd3};
        tbl[4] = '{dx: 3'd1, dy: 3'd1, req: 5'b00001, port: 3'd0};
        tbl[5] = '{dx: 3'd2, dy: 3'd0, req: 5'b00100, port: 3'd2};
        tbl[6] = '{dx: 3'd0, dy: 3'd7, req: 5'b10000, port: 3'd4};

        rst = 1'b1; in_valid = 1'b0; in_flit = '0; gnt_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_req", 32'(req_out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_drop", 32'(drop_err), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Routing table, one single-flit packet per entry.
        for (int i = 0; i < 7; i++) single_flit(i, tbl[i]);

        // 4-flit packet to South, grant held off for 5 request cycles.
        pk[0] = mk(2'b01, 1, 0, 8'hA0); pk[1] = mk(2'b00, 6, 6, 8'hA1);
        pk[2] = mk(2'b00, 2, 5, 8'hA2); pk[3] = mk(2'b10, 7, 3, 8'hA3);
        for (int i = 0; i < 4; i++) begin
            nxt(); in_valid = 1'b1; in_flit = pk[i]; #1;
            chk("b_ready", 32'(in_ready), 32'd1);
            chk("b_req_early", 32'(req_out), (i >= 2) ? 32'b01000 : 32'd0);
            chk("b_no_valid", 32'(out_valid), 32'd0);
        end
        for (int w = 0; w < 3; w++) begin
            nxt(); in_valid = 1'b0; #1;
            chk("b_req_wait", 32'(req_out), 32'b01000);
            chk("b_no_valid_wait", 32'(out_valid), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            nxt(); if (k == 0) gnt_in = 5'b01000; #1;
            chk("b_valid", 32'(out_valid), 32'd1);
            chk("b_flit", 32'(out_flit), 32'(pk[k]));
            chk("b_port", 32'(out_port), 32'd3);
        end
        nxt(); #1;
        chk("b_req_drop", 32'(req_out), 32'd0);
        chk("b_valid_drop", 32'(out_valid), 32'd0);
        nxt(); gnt_in = '0; #1;

        // Fill to DEPTH with no grant; extra flit offered while full, including the first pop cycle.
        pk[0] = mk(2'b01, 0, 1, 8'hB0); pk[1] = mk(2'b00, 3, 3, 8'hB1);
        pk[2] = mk(2'b00, 4, 4, 8'hB2); pk[3] = mk(2'b10, 5, 5, 8'hB3);
        xf    = mk(2'b11, 3, 1, 8'hBF);
        for (int i = 0; i < 4; i++) begin
            nxt(); in_valid = 1'b1; in_flit = pk[i]; #1;
            chk("c_ready_filling", 32'(in_ready), 32'd1);
        end
        for (int i = 0; i < 2; i++) begin
            nxt(); in_flit = xf; #1;
            chk("c_full", 32'(in_ready), 32'd0);
            chk("c_no_valid", 32'(out_valid), 32'd0);
        end
        nxt(); gnt_in = 5'b10000; #1;
        chk("c_full_on_pop", 32'(in_ready), 32'd0);
        chk("c_valid0", 32'(out_valid), 32'd1);
        chk("c_flit0", 32'(out_flit), 32'(pk[0]));
        for (int k = 1; k < 4; k++) begin
            nxt(); in_valid = 1'b0; #1;
            chk("c_valid", 32'(out_valid), 32'd1);
            chk("c_flit", 32'(out_flit), 32'(pk[k]));
            chk("c_port", 32'(out_port), 32'd4);
        end
        nxt(); #1;
        chk("c_req_drop", 32'(req_out), 32'd0);
        nxt(); gnt_in = '0; #1;
        chk("c_no_extra_req", 32'(req_out), 32'd0);
        chk("c_ready_after", 32'(in_ready), 32'd1);
        chk("c_no_drop", 32'(drop_err), 32'd0);
        nxt(); #1;
        chk("c_still_idle", 32'(req_out), 32'd0);

        // Stray body and tail flits arriving while idle.
        for (int j = 0; j < 2; j++) begin
            nxt(); in_valid = 1'b1; in_flit = mk((j == 0) ? 2'b00 : 2'b10, 3, 1, 8'(8'hC0 + j)); #1;
            chk("d_no_drop_yet", 32'(drop_err), 32'd0);
            nxt(); in_valid = 1'b0; #1;
            chk("d_drop", 32'(drop_err), 32'd1);
            chk("d_no_req", 32'(req_out), 32'd0);
            chk("d_no_valid", 32'(out_valid), 32'd0);
            nxt(); #1;
            chk("d_drop_pulse", 32'(drop_err), 32'd0);
            chk("d_no_req2", 32'(req_out), 32'd0);
            nxt(); #1;
            chk("d_no_req3", 32'(req_out), 32'd0);
        end

        // Back-to-back packets to East, grant stays high one cycle past the first tail.
        pk[0] = mk(2'b01, 3, 1, 8'hD0); pk[1] = mk(2'b10, 0, 0, 8'hD1);
        pk[2] = mk(2'b01, 3, 1, 8'hD2); pk[3] = mk(2'b10, 0, 0, 8'hD3);
        nxt(); in_valid = 1'b1; in_flit = pk[0]; #1;
        nxt(); in_flit = pk[1]; #1;
        chk("e_req_c1", 32'(req_out), 32'd0);
        nxt(); in_flit = pk[2]; #1;
        chk("e_req_c2", 32'(req_out), 32'b00100);
        chk("e_valid_c2", 32'(out_valid), 32'd0);
        nxt(); in_flit = pk[3]; gnt_in = 5'b00100; #1;
        chk("e_valid_c3", 32'(out_valid), 32'd1);
        chk("e_flit_c3", 32'(out_flit), 32'(pk[0]));
        nxt(); in_valid = 1'b0; #1;
        chk("e_valid_c4", 32'(out_valid), 32'd1);
        chk("e_flit_c4", 32'(out_flit), 32'(pk[1]));
        nxt(); #1;
        chk("e_req_gap", 32'(req_out), 32'd0);
        chk("e_stale_gnt", 32'(out_valid), 32'd0);
        nxt(); gnt_in = '0; #1;
        chk("e_req_again", 32'(req_out), 32'b00100);
        chk("e_valid_c6", 32'(out_valid), 32'd0);
        nxt(); gnt_in = 5'b00100; #1;
        chk("e_valid_c7", 32'(out_valid), 32'd1);
        chk("e_flit_c7", 32'(out_flit), 32'(pk[2]));
        nxt(); #1;
        chk("e_flit_c8", 32'(out_flit), 32'(pk[3]));
        nxt(); #1;
        chk("e_req_end", 32'(req_out), 32'd0);
        nxt(); gnt_in = '0; #1;

        // Asynchronous reset in the middle of a packet with 2 flits still buffered.
        pk[0] = mk(2'b01, 3, 1, 8'hE0); pk[1] = mk(2'b00, 1, 1, 8'hE1);
        pk[2] = mk(2'b00, 1, 1, 8'hE2); pk[3] = mk(2'b10, 1, 1, 8'hE3);
        for (int i = 0; i < 4; i++) begin
            nxt(); in_valid = 1'b1; in_flit = pk[i]; if (i == 3) gnt_in = 5'b00100; #1;
        end
        nxt(); in_valid = 1'b0; #1;
        chk("f_valid_before_rst", 32'(out_valid), 32'd1);
        nxt(); #1;
        rst = 1'b1; #1;
        chk("f_rst_req", 32'(req_out), 32'd0);
        chk("f_rst_valid", 32'(out_valid), 32'd0);
        chk("f_rst_ready", 32'(in_ready), 32'd1);
        gnt_in = '0;
        nxt(); rst = 1'b0; #1;
        for (int i = 0; i < 2; i++) begin
            nxt(); #1;
            chk("f_post_req", 32'(req_out), 32'd0);
            chk("f_post_drop", 32'(drop_err), 32'd0);
            chk("f_post_valid", 32'(out_valid), 32'd0);
        end

        // Randomized packets and strays against a flit-order scoreboard.
        strays = 0; drops = 0; tails = 0; in_pkt = 1'b0; pkt_port = 0; ncyc = 0;
        for (int p = 0; p < NPKT; p++) begin
            if ($urandom_range(0, 4) == 0) begin
                stim.push_back(mk(($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00,
                                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 8'($urandom)));
                strays++;
            end
            plen = int'($urandom_range(1, 5));
            px   = int'($urandom_range(0, 7));
            py   = int'($urandom_range(0, 7));
            if (plen == 1) begin
                stim.push_back(mk(2'b11, px, py, 8'($urandom)));
            end else begin
                stim.push_back(mk(2'b01, px, py, 8'($urandom)));
                for (int b = 1; b < plen - 1; b++)
                    stim.push_back(mk(2'b00, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 8'($urandom)));
                stim.push_back(mk(2'b10, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 8'($urandom)));
            end
        end

        nxt(); in_valid = 1'b0; gnt_in = '0; #1;
        while ((stim.size() > 0 || sb.size() > 0) && ncyc < 20000) begin
            exp_ready = (sb.size() < DEPTH);
            acc       = in_valid && exp_ready;
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_ready));
            if (in_pkt) begin
                chk("rnd_req_hold", 32'(req_out), 32'd1 << pkt_port);
                if (sb.size() > 0 && gnt_in[pkt_port]) chk("rnd_stream", 32'(out_valid), 32'd1);
            end else if (sb.size() > 0 && f_head(sb[0])) begin
                chk("rnd_req_route", 32'((req_out == 5'd0) || (32'(req_out) == (32'd1 << route_of(sb[0])))), 32'd1);
            end else begin
                chk("rnd_req_idle", 32'(req_out), 32'd0);
            end
            if (drop_err) begin
                chk("rnd_drop_legal", 32'(!in_pkt && sb.size() > 0 && !out_valid && !f_head(sb[0])), 32'd1);
                if (sb.size() > 0) void'(sb.pop_front());
                drops++;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("rnd_valid_when_empty", 32'(out_valid), 32'd0);
                end else begin
                    fr = sb.pop_front();
                    if (!in_pkt) begin
                        chk("rnd_head_first", 32'(f_head(fr)), 32'd1);
                        pkt_port = route_of(fr);
                        in_pkt   = 1'b1;
                    end
                    chk("rnd_flit", 32'(out_flit), 32'(fr));
                    chk("rnd_port", 32'(out_port), 32'(pkt_port));
                    chk("rnd_granted", 32'(gnt_in[pkt_port]), 32'd1);
                    if (f_tail(fr)) begin
                        in_pkt = 1'b0;
                        tails++;
                    end
                end
            end
            if (acc) begin
                sb.push_back(in_flit);
                void'(stim.pop_front());
            end
            req_prev = req_out;
            gnt_prev = gnt_in;
            nxt();
            // Registered arbiter: grants after seeing req, holds while req stays, drops a cycle after req.
            gnt_in = req_prev & (gnt_prev | (($urandom_range(0, 2) == 0) ? req_prev : 5'b0));
            if (stim.size() > 0 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_flit  = stim[0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            ncyc++;
        end
        chk("rnd_drained", 32'(stim.size() + sb.size()), 32'd0);
        chk("rnd_drop_count", 32'(drops), 32'(strays));
        chk("rnd_packet_count", 32'(tails), 32'(NPKT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
